// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - per-frame ball motion, scoring and serve sequencing for Pong
module ball_ctrl #(
    parameter int TABLE_LEFT   = 16,
    parameter int TABLE_RIGHT  = 624,
    parameter int TABLE_TOP    = 16,
    parameter int TABLE_BOTTOM = 464,
    parameter int BALL_HSIZE   = 8,
    parameter int BALL_VSIZE   = 8,
    parameter int INIT_SPEED   = 2,
    parameter int MAX_SPEED    = 12,
    parameter int VSPEED       = 2,
    parameter int SERVE_DELAY  = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vblank,
    input  logic        serve,
    input  logic        coll_paddle,
    input  logic        coll_wall,
    output logic [10:0] ball_h,
    output logic [10:0] ball_v,
    output logic        ball_dir,
    output logic [3:0]  ball_speed,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        game_over
);

    localparam logic [10:0] TL = 11'(TABLE_LEFT);
    localparam logic [10:0] TR = 11'(TABLE_RIGHT);
    localparam logic [10:0] TT = 11'(TABLE_TOP);
    localparam logic [10:0] TB = 11'(TABLE_BOTTOM);
    localparam logic [10:0] BH = 11'(BALL_HSIZE);
    localparam logic [10:0] BV = 11'(BALL_VSIZE);
    localparam logic [10:0] VS = 11'(VSPEED);
    localparam logic [10:0] CH = 11'((TABLE_LEFT + TABLE_RIGHT - BALL_HSIZE) / 2);
    localparam logic [10:0] CV = 11'((TABLE_TOP + TABLE_BOTTOM - BALL_VSIZE) / 2);
    localparam logic [3:0]  INIT = 4'(INIT_SPEED);
    localparam logic [3:0]  MAXS = 4'(MAX_SPEED);
    localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
    localparam int          CW   = $clog2(SERVE_DELAY + 1);
    localparam logic [CW-1:0] LAST_FRAME = CW'(SERVE_DELAY - 1);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic V_DOWN    = 1'b0;
    localparam logic V_UP      = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        EVAL,
        MOVE,
        SCORED
    } state_t;

    state_t          state;
    logic [2:0]      vb_sync;
    logic [2:0]      sv_sync;
    logic            frame_tick;
    logic            serve_pulse;
    logic            vdir;
    logic [CW-1:0]   frame_cnt;

    logic [10:0]     spd;
    logic [10:0]     h_next;
    logic [10:0]     v_next;
    logic            vdir_next;
    logic [3:0]      spd_up;
    logic            point_win;

    // Two sync flops then a registered rising-edge detect for both async inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            vb_sync     <= 3'b000;
            sv_sync     <= 3'b000;
            frame_tick  <= 1'b0;
            serve_pulse <= 1'b0;
        end else begin
            vb_sync     <= {vb_sync[1:0], vblank};
            sv_sync     <= {sv_sync[1:0], serve};
            frame_tick  <= vb_sync[1] & ~vb_sync[2];
            serve_pulse <= sv_sync[1] & ~sv_sync[2];
        end
    end

    always_comb begin
        spd       = {7'd0, ball_speed};
        h_next    = ball_h;
        v_next    = ball_v;
        vdir_next = vdir;
        if (ball_dir == DIR_LEFT) begin
            h_next = (ball_h <= TL + spd) ? TL : ball_h - spd;
        end else begin
            h_next = (ball_h + BH + spd >= TR) ? TR - BH : ball_h + spd;
        end
        if (vdir == V_UP) begin
            if (ball_v <= TT + VS) begin
                v_next    = TT;
                vdir_next = V_DOWN;
            end else begin
                v_next = ball_v - VS;
            end
        end else begin
            if (ball_v + BV + VS >= TB) begin
                v_next    = TB - BV;
                vdir_next = V_UP;
            end else begin
                v_next = ball_v + VS;
            end
        end
        spd_up    = (ball_speed >= MAXS) ? MAXS : ball_speed + 4'd1;
        point_win = ((ball_dir == DIR_LEFT) ? score_right : score_left) >= WIN - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ball_h      <= CH;
            ball_v      <= CV;
            ball_dir    <= DIR_RIGHT;
            ball_speed  <= INIT;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            game_over   <= 1'b0;
            vdir        <= V_DOWN;
            frame_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (serve_pulse) begin
                        if (game_over) begin
                            score_left  <= 4'd0;
                            score_right <= 4'd0;
                            game_over   <= 1'b0;
                        end
                        ball_h     <= CH;
                        ball_v     <= CV;
                        ball_speed <= INIT;
                        ball_dir   <= DIR_RIGHT;
                        vdir       <= V_DOWN;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (frame_tick) state <= EVAL;
                end
                EVAL: begin
                    if (coll_paddle) begin
                        ball_dir   <= ~ball_dir;
                        ball_speed <= spd_up;
                        state      <= MOVE;
                    end else if (coll_wall) begin
                        if (ball_dir == DIR_LEFT) begin
                            score_right <= (score_right < WIN) ? score_right + 4'd1 : score_right;
                        end else begin
                            score_left  <= (score_left < WIN) ? score_left + 4'd1 : score_left;
                        end
                        ball_h    <= CH;
                        ball_v    <= CV;
                        frame_cnt <= '0;
                        if (point_win) begin
                            game_over <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state     <= SCORED;
                        end
                    end else begin
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    ball_h <= h_next;
                    ball_v <= v_next;
                    vdir   <= vdir_next;
                    state  <= RUN;
                end
                SCORED: begin
                    // ball_dir is left untouched so the relaunch heads toward the conceding side
                    if (frame_tick) begin
                        if (frame_cnt == LAST_FRAME) begin
                            ball_speed <= INIT;
                            state      <= RUN;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - directed self-checking bench for ball_ctrl
module tb_ball_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic        serve = 1'b0;
    logic        coll_paddle = 1'b0;
    logic        coll_wall = 1'b0;
    logic [10:0] ball_h;
    logic [10:0] ball_v;
    logic        ball_dir;
    logic [3:0]  ball_speed;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic        game_over;

    int passed = 0;
    int total  = 0;

    ball_ctrl dut (
        .clk(clk),
        .reset(reset),
        .vblank(vblank),
        .serve(serve),
        .coll_paddle(coll_paddle),
        .coll_wall(coll_wall),
        .ball_h(ball_h),
        .ball_v(ball_v),
        .ball_dir(ball_dir),
        .ball_speed(ball_speed),
        .score_left(score_left),
        .score_right(score_right),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic frame();
        @(negedge clk);
        vblank = 1'b1;
        repeat (4) @(negedge clk);
        vblank = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic flag_frame(input logic p, input logic w);
        coll_paddle = p;
        coll_wall   = w;
        frame();
        coll_paddle = 1'b0;
        coll_wall   = 1'b0;
    endtask

    task automatic press_serve();
        @(negedge clk);
        serve = 1'b1;
        repeat (4) @(negedge clk);
        serve = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_pos(input string name, input logic [10:0] eh, input logic [10:0] ev);
        total++;
        if (ball_h !== eh) $display("FAIL %s_h: got %0d want %0d", name, ball_h, eh);
        else passed++;
        total++;
        if (ball_v !== ev) $display("FAIL %s_v: got %0d want %0d", name, ball_v, ev);
        else passed++;
    endtask

    task automatic check_state(input string name, input logic ed, input logic [3:0] es,
                               input logic [3:0] esl, input logic [3:0] esr, input logic ego);
        total++;
        if (ball_dir !== ed) $display("FAIL %s_dir: got %0d want %0d", name, ball_dir, ed);
        else passed++;
        total++;
        if (ball_speed !== es) $display("FAIL %s_speed: got %0d want %0d", name, ball_speed, es);
        else passed++;
        total++;
        if (score_left !== esl) $display("FAIL %s_score_left: got %0d want %0d", name, score_left, esl);
        else passed++;
        total++;
        if (score_right !== esr) $display("FAIL %s_score_right: got %0d want %0d", name, score_right, esr);
        else passed++;
        total++;
        if (game_over !== ego) $display("FAIL %s_game_over: got %0d want %0d", name, game_over, ego);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_pos("reset", 11'd316, 11'd236);
        check_state("reset", 1'b1, 4'd2, 4'd0, 4'd0, 1'b0);
        frames(5);
        check_pos("idle_no_serve", 11'd316, 11'd236);
        check_state("idle_no_serve", 1'b1, 4'd2, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_serve_run();
        press_serve();
        frames(3);
        check_pos("run3", 11'd322, 11'd242);
        check_state("run3", 1'b1, 4'd2, 4'd0, 4'd0, 1'b0);
        press_serve();
        check_pos("serve_ignored", 11'd322, 11'd242);
    endtask

    task automatic test_paddle();
        logic [10:0] exp_h [10];
        exp_h = '{11'd323, 11'd318, 11'd324, 11'd317, 11'd325,
                  11'd316, 11'd326, 11'd315, 11'd327, 11'd315};
        flag_frame(1'b1, 1'b1);
        check_pos("paddle_first", 11'd319, 11'd244);
        check_state("paddle_first", 1'b0, 4'd3, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] es;
            es = (i >= 8) ? 4'd12 : 4'(4 + i);
            flag_frame(1'b1, 1'b0);
            total++;
            if (ball_speed !== es) $display("FAIL paddle_speed_%0d: got %0d want %0d", i, ball_speed, es);
            else passed++;
            total++;
            if (ball_h !== exp_h[i]) $display("FAIL paddle_h_%0d: got %0d want %0d", i, ball_h, exp_h[i]);
            else passed++;
        end
        check_pos("paddle_max", 11'd315, 11'd264);
        check_state("paddle_max", 1'b0, 4'd12, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_wall_serve_delay();
        flag_frame(1'b0, 1'b1);
        check_pos("wall_park", 11'd316, 11'd236);
        check_state("wall_park", 1'b0, 4'd12, 4'd0, 4'd1, 1'b0);
        frames(59);
        check_pos("parked_59", 11'd316, 11'd236);
        frames(2);
        check_pos("relaunch", 11'd314, 11'd238);
        check_state("relaunch", 1'b0, 4'd2, 4'd0, 4'd1, 1'b0);
    endtask

    task automatic test_vertical();
        frames(108);
        total++;
        if (ball_v !== 11'd454) $display("FAIL v_454: got %0d want 454", ball_v);
        else passed++;
        frame();
        total++;
        if (ball_v !== 11'd456) $display("FAIL v_bottom: got %0d want 456", ball_v);
        else passed++;
        frames(219);
        total++;
        if (ball_v !== 11'd18) $display("FAIL v_18: got %0d want 18", ball_v);
        else passed++;
        frame();
        total++;
        if (ball_v !== 11'd16) $display("FAIL v_top: got %0d want 16", ball_v);
        else passed++;
        frame();
        total++;
        if (ball_v !== 11'd18) $display("FAIL v_bounce_down: got %0d want 18", ball_v);
        else passed++;
    endtask

    task automatic test_game_over();
        for (int i = 0; i < 7; i++) begin
            flag_frame(1'b0, 1'b1);
            frames(60);
        end
        check_state("score8", 1'b0, 4'd2, 4'd0, 4'd8, 1'b0);
        flag_frame(1'b0, 1'b1);
        check_pos("game_over", 11'd316, 11'd236);
        check_state("game_over", 1'b0, 4'd2, 4'd0, 4'd9, 1'b1);
        frames(2);
        check_pos("game_over_idle", 11'd316, 11'd236);
        press_serve();
        check_state("restart", 1'b1, 4'd2, 4'd0, 4'd0, 1'b0);
        frame();
        check_pos("restart_move", 11'd318, 11'd238);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_pos("mid_reset", 11'd316, 11'd236);
        check_state("mid_reset", 1'b1, 4'd2, 4'd0, 4'd0, 1'b0);
        frame();
        check_pos("mid_reset_idle", 11'd316, 11'd236);
    endtask

    task automatic test_score_left();
        press_serve();
        frame();
        check_pos("left_pre", 11'd318, 11'd238);
        flag_frame(1'b0, 1'b1);
        check_pos("left_point", 11'd316, 11'd236);
        check_state("left_point", 1'b1, 4'd2, 4'd1, 4'd0, 1'b0);
        frames(61);
        check_pos("left_relaunch", 11'd318, 11'd238);
    endtask

    initial begin
        test_reset();
        test_serve_run();
        test_paddle();
        test_wall_serve_delay();
        test_vertical();
        test_game_over();
        test_reset_mid_run();
        test_score_left();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
